alu_seq: RTL and testbench



---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu_seq_if.sv | 18 +
 rtl/alu_seq_mul_iter.sv | 49 ++++
 rtl/alu_seq.sv | 94 +++++++++
 tb/tb_alu_seq.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU types: opcode and sequencer state encodings.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD   = 3'd0,
    OP_SUB   = 3'd1,
    OP_MUL   = 3'd2,
    OP_PASSB = 3'd3,
    OP_INCA  = 3'd4,
    OP_SHR   = 3'd5,
    OP_ZERO  = 3'd6,
    OP_AND   = 3'd7
  } op_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/alu_seq_if.sv
// Operation request / result channel between issue and writeback.
interface alu_seq_if import alu_pkg::*; #(parameter int WIDTH = 16) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  op_t              op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             z;
  logic             c;

  modport master (output in_valid, a, b, op, out_ready,
                  input  in_ready, out_valid, result, z, c);
  modport slave  (input  in_valid, a, b, op, out_ready,
                  output in_ready, out_valid, result, z, c);
endinterface

// File: rtl/alu_seq_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, WIDTH cycles.
// done is asserted combinationally on the final iteration; prod is the
// accumulator value that iteration produces, so the owner can latch it
// on the same edge the engine retires.
module mul_iter #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);
  localparam int CW = $clog2(WIDTH);

  logic               busy;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;

  assign prod = acc + (mplier[0] ? mcand : '0);
  assign done = busy && (cnt == CW'(WIDTH - 1));

  // Operand capture on start, then shift-add until the last bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy   <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
    end else if (busy) begin
      acc    <= prod;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end
endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle ops plus an iterative multiply, with a
// registered result/flags held until the consumer takes them.
module alu_seq import alu_pkg::*; #(
  parameter int WIDTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  alu_seq_if.slave   bus
);
  localparam int SHW = $clog2(WIDTH);

  state_t             state, state_nxt;
  logic               accept, load, mul_start, mul_done;
  logic [2*WIDTH-1:0] mul_prod;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   alu_res, res_nxt;
  logic               alu_c, c_nxt;

  // A retiring result frees the output register in the same cycle.
  assign bus.in_ready = !rst && (state == S_IDLE) && (!bus.out_valid || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign mul_start    = accept && (bus.op == OP_MUL);

  mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk   (clk),
    .rst   (rst),
    .start (mul_start),
    .a     (bus.a),
    .b     (bus.b),
    .done  (mul_done),
    .prod  (mul_prod)
  );

  // Single-cycle datapath; carry ops share one WIDTH+1 adder result.
  always_comb begin
    sum     = '0;
    alu_res = '0;
    alu_c   = 1'b0;
    case (bus.op)
      OP_ADD:   begin sum = {1'b0, bus.a} + {1'b0, bus.b}; alu_res = sum[WIDTH-1:0]; alu_c = sum[WIDTH]; end
      OP_SUB:   begin sum = {1'b0, bus.a} - {1'b0, bus.b}; alu_res = sum[WIDTH-1:0]; alu_c = sum[WIDTH]; end
      OP_INCA:  begin sum = {1'b0, bus.a} + 1'b1;          alu_res = sum[WIDTH-1:0]; alu_c = sum[WIDTH]; end
      OP_PASSB: alu_res = bus.b;
      OP_SHR:   alu_res = bus.a >> bus.b[SHW-1:0];
      OP_AND:   alu_res = bus.a & bus.b;
      default:  alu_res = '0;
    endcase
  end

  assign res_nxt = (state == S_MUL) ? mul_prod[WIDTH-1:0] : alu_res;
  assign c_nxt   = (state == S_MUL) ? |mul_prod[2*WIDTH-1:WIDTH] : alu_c;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next state and result-load strobe.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      S_IDLE: begin
        if (mul_start)   state_nxt = S_MUL;
        else if (accept) load      = 1'b1;
      end
      S_MUL: begin
        if (mul_done) begin
          load      = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output register: load wins over retire so back-to-back ops stream.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.result    <= '0;
      bus.z         <= 1'b0;
      bus.c         <= 1'b0;
    end else if (load) begin
      bus.out_valid <= 1'b1;
      bus.result    <= res_nxt;
      bus.z         <= (res_nxt == '0);
      bus.c         <= c_nxt;
    end else if (bus.out_valid && bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq at WIDTH=16 and WIDTH=8.
module tb_alu_seq;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(16)) i16 ();
  alu_seq_if #(.WIDTH(8))  i8  ();

  alu_seq #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(i16));
  alu_seq #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(i8));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain arithmetic on 64-bit values, masked to w bits.
  function automatic void model(input int w, input op_t o, input longint unsigned av,
                                input longint unsigned bv, output longint unsigned r,
                                output bit cf);
    longint unsigned m, t;
    m  = (64'd1 << w) - 1;
    av = av & m;
    bv = bv & m;
    cf = 1'b0;
    case (o)
      OP_ADD:   begin t = av + bv; r = t & m; cf = (t > m); end
      OP_SUB:   begin r = (av - bv) & m; cf = (av < bv); end
      OP_MUL:   begin t = av * bv; r = t & m; cf = ((t >> w) != 0); end
      OP_PASSB: r = bv;
      OP_INCA:  begin t = av + 1; r = t & m; cf = (t > m); end
      OP_SHR:   r = av >> (bv % w);
      OP_ZERO:  r = 0;
      default:  r = av & bv;
    endcase
  endfunction

  task automatic run16(input op_t o, input logic [15:0] av, input logic [15:0] bv, input int hold);
    longint unsigned r;
    bit cf;
    int n, lat, bad;
    model(16, o, av, bv, r, cf);
    i16.op = o; i16.a = av; i16.b = bv; i16.in_valid = 1'b1; i16.out_ready = 1'b0;
    #1;
    n = 0;
    while (!i16.in_ready && n < 64) begin @(posedge clk); #1; n++; end
    chk("w16_accept_timeout", 64'(n < 64), 64'd1);
    @(posedge clk); #1;
    // Scramble inputs after accept: captured operands must not follow them.
    i16.in_valid = 1'b0; i16.a = 16'($urandom); i16.b = 16'($urandom);
    i16.op = op_t'($urandom_range(0, 7));
    lat = 0; bad = 0;
    while (!i16.out_valid && lat < 64) begin
      if (i16.in_ready) bad++;
      @(posedge clk); #1; lat++;
    end
    chk("w16_latency", 64'(lat), (o == OP_MUL) ? 64'd16 : 64'd0);
    chk("w16_busy_ready", 64'(bad), 64'd0);
    chk("w16_result", 64'(i16.result), 64'(r));
    chk("w16_z", 64'(i16.z), 64'(r == 0));
    chk("w16_c", 64'(i16.c), 64'(cf));
    repeat (hold) begin
      @(posedge clk); #1;
      chk("w16_hold", {46'd0, i16.out_valid, i16.in_ready, i16.result}, {46'd0, 1'b1, 1'b0, 16'(r)});
    end
    i16.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("w16_retire", 64'(i16.out_valid), 64'd0);
    i16.out_ready = 1'b0;
  endtask

  task automatic run8(input op_t o, input logic [7:0] av, input logic [7:0] bv);
    longint unsigned r;
    bit cf;
    int n, lat;
    model(8, o, av, bv, r, cf);
    i8.op = o; i8.a = av; i8.b = bv; i8.in_valid = 1'b1; i8.out_ready = 1'b0;
    #1;
    n = 0;
    while (!i8.in_ready && n < 64) begin @(posedge clk); #1; n++; end
    chk("w8_accept_timeout", 64'(n < 64), 64'd1);
    @(posedge clk); #1;
    i8.in_valid = 1'b0; i8.a = 8'($urandom); i8.b = 8'($urandom);
    lat = 0;
    while (!i8.out_valid && lat < 64) begin @(posedge clk); #1; lat++; end
    chk("w8_latency", 64'(lat), (o == OP_MUL) ? 64'd8 : 64'd0);
    chk("w8_result", 64'(i8.result), 64'(r));
    chk("w8_z", 64'(i8.z), 64'(r == 0));
    chk("w8_c", 64'(i8.c), 64'(cf));
    i8.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("w8_retire", 64'(i8.out_valid), 64'd0);
    i8.out_ready = 1'b0;
  endtask

  initial begin
    op_t ops[7];
    longint unsigned r;
    bit cf;
    int bad;
    ops = '{OP_ADD, OP_SUB, OP_PASSB, OP_INCA, OP_SHR, OP_ZERO, OP_AND};
    rst = 1'b1;
    i16.in_valid = 1'b0; i16.out_ready = 1'b0; i16.a = '0; i16.b = '0; i16.op = OP_ADD;
    i8.in_valid  = 1'b0; i8.out_ready  = 1'b0; i8.a  = '0; i8.b  = '0; i8.op  = OP_ADD;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(i16.out_valid), 64'd0);
    chk("rst_result", 64'(i16.result), 64'd0);
    chk("rst_zc", {62'd0, i16.z, i16.c}, 64'd0);
    chk("rst_in_ready", 64'(i16.in_ready), 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(i16.in_ready), 64'd1);

    // Back-to-back single-cycle ops, one result per cycle.
    i16.out_ready = 1'b1; i16.a = 16'd22; i16.b = 16'd10;
    i16.in_valid = 1'b1; i16.op = ops[0];
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      model(16, ops[i], 22, 10, r, cf);
      chk("b2b_valid", 64'(i16.out_valid), 64'd1);
      chk("b2b_result", 64'(i16.result), 64'(r));
      chk("b2b_zc", {62'd0, i16.z, i16.c}, {62'd0, 1'(r == 0), cf});
      chk("b2b_in_ready", 64'(i16.in_ready), 64'd1);
      if (i < 6) i16.op = ops[i + 1];
      else       i16.in_valid = 1'b0;
    end
    @(posedge clk); #1;
    chk("b2b_drain", 64'(i16.out_valid), 64'd0);
    i16.out_ready = 1'b0;

    // Directed corner cases.
    run16(OP_MUL, 16'd22, 16'd10, 0);
    run16(OP_SUB, 16'd10, 16'd22, 0);
    run16(OP_ADD, 16'hFFFF, 16'd1, 0);
    run16(OP_MUL, 16'h0100, 16'h0100, 0);
    run16(OP_INCA, 16'hFFFF, 16'd0, 0);
    run16(OP_SHR, 16'h8000, 16'd15, 0);

    // Backpressure: result held, queued SUB waits, then streams in.
    i16.a = 16'd22; i16.b = 16'd10; i16.op = OP_ADD; i16.in_valid = 1'b1; i16.out_ready = 1'b0;
    @(posedge clk); #1;
    i16.op = OP_SUB;
    repeat (5) begin
      chk("bp_hold", {46'd0, i16.out_valid, i16.in_ready, i16.result}, {46'd0, 1'b1, 1'b0, 16'd32});
      @(posedge clk); #1;
    end
    i16.out_ready = 1'b1;
    #1;
    chk("bp_ready_rise", 64'(i16.in_ready), 64'd1);
    @(posedge clk); #1;
    i16.in_valid = 1'b0;
    chk("bp_new_valid", 64'(i16.out_valid), 64'd1);
    chk("bp_new_result", 64'(i16.result), 64'd12);
    @(posedge clk); #1;
    chk("bp_drain", 64'(i16.out_valid), 64'd0);
    i16.out_ready = 1'b0;

    // Reset seven cycles into a multiply aborts it.
    i16.a = 16'd22; i16.b = 16'd10; i16.op = OP_MUL; i16.in_valid = 1'b1; i16.out_ready = 1'b1;
    @(posedge clk); #1;
    i16.in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", 64'(i16.in_ready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    bad = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (i16.out_valid) bad++;
    end
    chk("mid_rst_no_result", 64'(bad), 64'd0);
    i16.out_ready = 1'b0;
    run16(OP_ADD, 16'd1, 16'd1, 0);

    // Randomized ops with random consumer stall.
    for (int i = 0; i < 120; i++)
      run16(op_t'($urandom_range(0, 7)), 16'($urandom), 16'($urandom), $urandom_range(0, 3));

    // Narrow instance.
    run8(OP_MUL, 8'd15, 8'd17);
    run8(OP_MUL, 8'd16, 8'd16);
    for (int i = 0; i < 30; i++)
      run8(op_t'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
